// File: rtl/banner_screen.sv
// Banner renderer: draws one of four built-in 5x7-font messages into the VGA
// pixel-write port, one pixel per cycle, in draw or erase mode.
module banner_screen #(
   parameter int         XSCREEN   = 640,
   parameter int         YSCREEN   = 480,
   parameter int         X0        = 120,
   parameter int         Y0        = 200,
   parameter int         STEP_X    = 80,
   parameter int         STEP_Y    = 50,
   parameter int         X_PAD     = 20,
   parameter int         CELL_W    = 8,
   parameter int         CELL_H    = 7,
   parameter logic [8:0] BG_COLOR  = 9'b000_000_000,
   parameter int         MAX_CHARS = 6
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       start,
   input  logic       abort,
   input  logic [1:0] msg_sel,
   input  logic [8:0] fg_color,
   input  logic       diag,
   input  logic       erase,
   output logic       busy,
   output logic       done,
   output logic [9:0] VGA_x,
   output logic [8:0] VGA_y,
   output logic [8:0] VGA_color,
   output logic       VGA_write
);

   localparam int GLYPH_W = 5 * CELL_W;
   localparam int GLYPH_H = 7 * CELL_H;
   localparam int PX_W    = $clog2(GLYPH_W);
   localparam int PY_W    = $clog2(GLYPH_H);
   localparam int IDX_W   = $clog2(MAX_CHARS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic             start_q;
   logic [1:0]       msg_q;
   logic [8:0]       fg_q;
   logic             diag_q;
   logic             erase_q;
   logic [PX_W-1:0]  px_q;
   logic [PY_W-1:0]  py_q;
   logic [IDX_W-1:0] idx_q;
   logic             busy_q;
   logic             done_q;
   logic [9:0]       x_q;
   logic [8:0]       y_q;
   logic [8:0]       color_q;
   logic             write_q;

   logic [3:0]       code_d;
   logic [34:0]      glyph_d;
   logic [2:0]       col_d;
   logic [2:0]       row_d;
   logic [5:0]       bit_idx_d;
   logic             font_bit_d;
   logic [10:0]      x_d;
   logic [10:0]      y_d;
   logic             clip_d;
   logic             last_px_d;
   logic             last_py_d;
   logic             last_idx_d;
   logic             start_edge_d;

   // Letter codes: L0 O1 S2 E3 R4 W5 I6 N7 A8 D9 Y10 P11 U12
   function automatic logic [3:0] char_code(input logic [1:0] msg, input logic [IDX_W-1:0] idx);
      logic [3:0] c;
      c = 4'd0;
      case (msg)
         2'd0: case (idx)  // LOSER
            3'd0: c = 4'd0;  3'd1: c = 4'd1;  3'd2: c = 4'd2;
            3'd3: c = 4'd3;  3'd4: c = 4'd4;  default: c = 4'd0;
         endcase
         2'd1: case (idx)  // WINNER
            3'd0: c = 4'd5;  3'd1: c = 4'd6;  3'd2: c = 4'd7;
            3'd3: c = 4'd7;  3'd4: c = 4'd3;  3'd5: c = 4'd4;
            default: c = 4'd0;
         endcase
         2'd2: case (idx)  // READY
            3'd0: c = 4'd4;  3'd1: c = 4'd3;  3'd2: c = 4'd8;
            3'd3: c = 4'd9;  3'd4: c = 4'd10; default: c = 4'd0;
         endcase
         2'd3: case (idx)  // PAUSE
            3'd0: c = 4'd11; 3'd1: c = 4'd8;  3'd2: c = 4'd12;
            3'd3: c = 4'd2;  3'd4: c = 4'd3;  default: c = 4'd0;
         endcase
         default: c = 4'd0;
      endcase
      return c;
   endfunction

   function automatic logic [IDX_W-1:0] msg_len(input logic [1:0] msg);
      case (msg)
         2'd1:    return IDX_W'(6);
         default: return IDX_W'(5);
      endcase
   endfunction

   // Row 0 occupies the top five bits; bit 4 of each row is font column 0.
   function automatic logic [34:0] glyph(input logic [3:0] code);
      case (code)
         4'd0:    return 35'b10000_10000_10000_10000_10000_10000_11111; // L
         4'd1:    return 35'b01110_10001_10001_10001_10001_10001_01110; // O
         4'd2:    return 35'b01111_10000_10000_01110_00001_00001_11110; // S
         4'd3:    return 35'b11111_10000_10000_11110_10000_10000_11111; // E
         4'd4:    return 35'b11110_10001_10001_11110_10100_10010_10001; // R
         4'd5:    return 35'b10001_10001_10001_10101_10101_10101_01010; // W
         4'd6:    return 35'b01110_00100_00100_00100_00100_00100_01110; // I
         4'd7:    return 35'b10001_11001_10101_10011_10001_10001_10001; // N
         4'd8:    return 35'b01110_10001_10001_11111_10001_10001_10001; // A
         4'd9:    return 35'b11110_10001_10001_10001_10001_10001_11110; // D
         4'd10:   return 35'b10001_10001_01010_00100_00100_00100_00100; // Y
         4'd11:   return 35'b11110_10001_10001_11110_10000_10000_10000; // P
         4'd12:   return 35'b10001_10001_10001_10001_10001_10001_01110; // U
         default: return 35'b00000_00000_00000_00000_00000_00000_00000;
      endcase
   endfunction

   // Pixel address, font lookup, clip test and counter wrap flags.
   always_comb begin
      code_d       = char_code(msg_q, idx_q);
      glyph_d      = glyph(code_d);
      col_d        = 3'(int'(px_q) / CELL_W);
      row_d        = 3'(int'(py_q) / CELL_H);
      bit_idx_d    = 6'(34 - 5 * int'(row_d) - int'(col_d));
      font_bit_d   = glyph_d[bit_idx_d];
      x_d          = 11'(X0) + 11'(int'(idx_q) * STEP_X) + 11'(X_PAD) + 11'(px_q);
      y_d          = 11'(Y0) + (diag_q ? 11'(int'(idx_q) * STEP_Y) : 11'd0) + 11'(py_q);
      clip_d       = (x_d >= 11'(XSCREEN)) || (y_d >= 11'(YSCREEN));
      last_px_d    = (px_q == PX_W'(GLYPH_W - 1));
      last_py_d    = (py_q == PY_W'(GLYPH_H - 1));
      last_idx_d   = (idx_q == msg_len(msg_q) - IDX_W'(1));
      start_edge_d = start & ~start_q;
   end

   // Control FSM, pixel counters and registered VGA outputs.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         msg_q   <= 2'd0;
         fg_q    <= 9'd0;
         diag_q  <= 1'b0;
         erase_q <= 1'b0;
         px_q    <= '0;
         py_q    <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         x_q     <= 10'd0;
         y_q     <= 9'd0;
         color_q <= BG_COLOR;
         write_q <= 1'b0;
      end else begin
         start_q <= start;
         case (state_q)
            IDLE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               write_q <= 1'b0;
               if (start_edge_d && !abort) begin
                  msg_q   <= msg_sel;
                  fg_q    <= fg_color;
                  diag_q  <= diag;
                  erase_q <= erase;
                  px_q    <= '0;
                  py_q    <= '0;
                  idx_q   <= '0;
                  state_q <= DRAW;
               end else begin
                  state_q <= IDLE;
               end
            end
            DRAW: begin
               if (abort) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
                  write_q <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  x_q     <= x_d[9:0];
                  y_q     <= y_d[8:0];
                  color_q <= (!erase_q && font_bit_d) ? fg_q : BG_COLOR;
                  write_q <= !clip_d;
                  if (last_px_d) begin
                     px_q <= '0;
                     if (last_py_d) begin
                        py_q <= '0;
                        if (last_idx_d) begin
                           state_q <= DONE;
                        end else begin
                           idx_q <= idx_q + IDX_W'(1);
                        end
                     end else begin
                        py_q <= py_q + PY_W'(1);
                     end
                  end else begin
                     px_q <= px_q + PX_W'(1);
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               write_q <= 1'b0;
               if (!start) begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  done_q  <= 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               write_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign VGA_x     = x_q;
   assign VGA_y     = y_q;
   assign VGA_color = color_q;
   assign VGA_write = write_q;

endmodule
